soc_console_status_mon: RTL and testbench

- Passive synthesizable monitor on the CPU-to-memory 128-bit AXI write path, downstream of the memory-slave interface. It consumes the beats that interface accepts.
- Console path: extracts console characters written to a fixed mailbox address and queues them in a FIFO for a drain port (UART model or log sink).
- Test-status path: detects end-of-test magic values on writeback data and flags a retire watchdog timeout.
- It never drives AXI ready signals.

---
 rtl/soc_console_status_mon.sv | 171 +++++++++++++++++
 tb/tb_soc_console_status_mon.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_console_status_mon.sv
// Passive AXI write-path sniffer: mailbox console characters into a FIFO,
// end-of-test magic detection on writeback, and a retire watchdog.
module soc_console_status_mon #(
  parameter logic [31:0] CONSOLE_ADDR = 32'h01ff_fff0,
  parameter int          FIFO_DEPTH   = 16,
  parameter int          WD_CYCLES    = 50000,
  parameter logic [63:0] PASS_MAGIC   = 64'h0000_0004_4433_3222,
  parameter logic [63:0] FAIL_MAGIC   = 64'h0000_0023_8234_8720
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          awvalid,
  input  logic                          awready,
  input  logic [31:0]                   awaddr,
  input  logic [3:0]                    awlen,
  input  logic                          wvalid,
  input  logic                          wready,
  input  logic                          wlast,
  input  logic [15:0]                   wstrb,
  input  logic [127:0]                  wdata,
  input  logic                          retire0,
  input  logic                          retire1,
  input  logic                          wb_vld0,
  input  logic [63:0]                   wb_data0,
  input  logic                          wb_vld1,
  input  logic [63:0]                   wb_data1,
  output logic                          char_valid,
  output logic [7:0]                    char_data,
  input  logic                          char_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          ovf_flag,
  output logic                          proto_err,
  output logic                          test_done,
  output logic                          test_pass,
  output logic                          wd_timeout
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(WD_CYCLES);
  localparam logic [WW-1:0] WD_LAST = WW'(WD_CYCLES - 1);

  typedef enum logic {IDLE, DATA} state_t;

  state_t        state, state_nx;
  logic [31:0]   addr_q, cur_addr;
  logic [3:0]    len_q, cur_len;
  logic          aw_hs, w_hs, beat, proto_hit;
  logic          lane_ok, push, push_ok, pop, full;
  logic [7:0]    lane_byte;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [WW-1:0] win_cnt;
  logic          seen, wd_last, wd_fire, pass_m, fail_m;
  logic          unused_wdata;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign unused_wdata = ^{wdata[127:104], wdata[95:72], wdata[63:40], wdata[31:8]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
      len_q  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && aw_hs) begin
        addr_q <= awaddr;
        len_q  <= awlen;
      end
    end
  end

  // A W beat coinciding with the AW handshake uses the incoming AW fields.
  always_comb begin
    state_nx  = state;
    beat      = 1'b0;
    proto_hit = 1'b0;
    cur_addr  = addr_q;
    cur_len   = len_q;
    case (state)
      IDLE: begin
        if (aw_hs) begin
          cur_addr = awaddr;
          cur_len  = awlen;
          beat     = w_hs;
          if (!(w_hs && wlast)) state_nx = DATA;
        end else if (w_hs) begin
          proto_hit = 1'b1;
        end
      end
      DATA: begin
        beat = w_hs;
        if (w_hs && wlast) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    lane_ok   = 1'b1;
    lane_byte = wdata[7:0];
    case (wstrb)
      16'h000f: lane_byte = wdata[7:0];
      16'h00f0: lane_byte = wdata[39:32];
      16'h0f00: lane_byte = wdata[71:64];
      16'hf000: lane_byte = wdata[103:96];
      default:  lane_ok   = 1'b0;
    endcase
  end

  assign push       = beat && (cur_len == 4'd0) && (cur_addr == CONSOLE_ADDR) && lane_ok;
  assign char_valid = (fifo_count != '0);
  assign full       = (fifo_count == CW'(FIFO_DEPTH));
  assign pop        = char_valid & char_ready;
  assign push_ok    = push & (!full | pop);
  assign char_data  = char_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= lane_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      ovf_flag   <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (push && !push_ok) ovf_flag  <= 1'b1;
      if (proto_hit)        proto_err <= 1'b1;
    end
  end

  // Retirement in the last window cycle still counts for that window.
  assign wd_last = (win_cnt == WD_LAST);
  assign wd_fire = wd_last && !(seen || retire0 || retire1);
  assign pass_m  = (wb_vld0 && wb_data0 == PASS_MAGIC) || (wb_vld1 && wb_data1 == PASS_MAGIC);
  assign fail_m  = (wb_vld0 && wb_data0 == FAIL_MAGIC) || (wb_vld1 && wb_data1 == FAIL_MAGIC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt    <= '0;
      seen       <= 1'b0;
      wd_timeout <= 1'b0;
      test_done  <= 1'b0;
      test_pass  <= 1'b0;
    end else begin
      win_cnt <= wd_last ? '0 : win_cnt + WW'(1);
      seen    <= wd_last ? 1'b0 : (seen | retire0 | retire1);
      if (wd_fire) wd_timeout <= 1'b1;
      if (!test_done) begin
        if (pass_m || fail_m) begin
          test_done <= 1'b1;
          test_pass <= pass_m & ~fail_m;
        end else if (wd_fire) begin
          test_done <= 1'b1;
          test_pass <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_soc_console_status_mon.sv
// Scoreboarded bench: expected console characters are queued at stimulus
// time and compared as the drain port accepts them.
module tb_soc_console_status_mon;
  localparam logic [31:0] CADDR = 32'h01ff_fff0;
  localparam logic [63:0] PASS  = 64'h0000_0004_4433_3222;
  localparam logic [63:0] FAILV = 64'h0000_0023_8234_8720;

  logic         clk = 1'b0, rst;
  logic         awvalid, awready, wvalid, wready, wlast;
  logic [31:0]  awaddr;
  logic [3:0]   awlen;
  logic [15:0]  wstrb;
  logic [127:0] wdata;
  logic         retire0, retire1, wb_vld0, wb_vld1;
  logic [63:0]  wb_data0, wb_data1;
  logic         char_valid, char_ready;
  logic [7:0]   char_data;
  logic [4:0]   fifo_count;
  logic         ovf_flag, proto_err, test_done, test_pass, wd_timeout;

  int n_chk = 0, n_err = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  soc_console_status_mon #(.CONSOLE_ADDR(CADDR), .FIFO_DEPTH(16), .WD_CYCLES(8),
                           .PASS_MAGIC(PASS), .FAIL_MAGIC(FAILV)) dut (
    .clk(clk), .rst(rst), .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .awlen(awlen), .wvalid(wvalid), .wready(wready), .wlast(wlast), .wstrb(wstrb),
    .wdata(wdata), .retire0(retire0), .retire1(retire1), .wb_vld0(wb_vld0),
    .wb_data0(wb_data0), .wb_vld1(wb_vld1), .wb_data1(wb_data1),
    .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
    .fifo_count(fifo_count), .ovf_flag(ovf_flag), .proto_err(proto_err),
    .test_done(test_done), .test_pass(test_pass), .wd_timeout(wd_timeout));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_aw(input logic [31:0] a, input logic [3:0] l);
    awvalid = 1'b1; awready = 1'b1; awaddr = a; awlen = l;
  endtask

  task automatic set_w(input logic [15:0] s, input logic [7:0] ch, input bit last);
    logic [127:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    case (s)
      16'h00f0: d[39:32]  = ch;
      16'h0f00: d[71:64]  = ch;
      16'hf000: d[103:96] = ch;
      default:  d[7:0]    = ch;
    endcase
    wvalid = 1'b1; wready = 1'b1; wlast = last; wstrb = s; wdata = d;
  endtask

  task automatic clr_bus();
    awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0; wstrb = '0;
  endtask

  task automatic mb_write(input logic [31:0] a, input logic [3:0] l, input logic [15:0] s,
                          input logic [7:0] ch, input bit same, input bit exp_push);
    set_aw(a, l);
    if (same) set_w(s, ch, 1'b1);
    else begin tick(); awvalid = 1'b0; set_w(s, ch, 1'b1); end
    if (exp_push) exp_q.push_back(ch);
    tick();
    clr_bus();
  endtask

  task automatic drain();
    char_ready = 1'b1;
    for (int i = 0; i < 40 && fifo_count != 0; i++) tick();
    char_ready = 1'b0;
    @(negedge clk);
    chk("drain_empty", fifo_count, 0);
    chk("sb_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out"}, {char_valid, char_data, fifo_count, ovf_flag, proto_err,
                        test_done, test_pass, wd_timeout}, 0);
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst && char_valid && char_ready) begin
      if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        chk("char_data", char_data, e);
      end
    end
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL global_timeout: simulation did not finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    rst = 1'b1; clr_bus(); awready = 1'b0; awaddr = '0; awlen = '0; wready = 1'b0;
    wdata = '0; retire0 = 1'b1; retire1 = 1'b0; wb_vld0 = 1'b0; wb_vld1 = 1'b0;
    wb_data0 = '0; wb_data1 = '0; char_ready = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");
    tick(); rst = 1'b0;

    // single beat, lane 1, drained immediately
    char_ready = 1'b1;
    mb_write(CADDR, 4'd0, 16'h00f0, 8'h41, 1'b0, 1'b1);
    @(negedge clk);
    chk("t1_valid", char_valid, 1);
    chk("t1_data", char_data, 8'h41);
    tick();
    @(negedge clk);
    chk("t1_count", fifo_count, 0);
    char_ready = 1'b0;

    // four lanes with AW+W together
    mb_write(CADDR, 4'd0, 16'h000f, "a", 1'b1, 1'b1);
    mb_write(CADDR, 4'd0, 16'h00f0, "b", 1'b1, 1'b1);
    mb_write(CADDR, 4'd0, 16'h0f00, "c", 1'b1, 1'b1);
    mb_write(CADDR, 4'd0, 16'hf000, "d", 1'b1, 1'b1);
    @(negedge clk);
    chk("t2_count", fifo_count, 4);
    drain();

    // overflow: 17th write dropped, then push+pop while full
    for (int i = 0; i < 17; i++) begin
      logic [15:0] s;
      s = 16'h000f << (4 * (i % 4));
      mb_write(CADDR, 4'd0, s, 8'h41 + 8'(i), 1'b1, i < 16);
    end
    @(negedge clk);
    chk("t3_count", fifo_count, 16);
    chk("t3_ovf", ovf_flag, 1);
    char_ready = 1'b1;
    mb_write(CADDR, 4'd0, 16'h0f00, 8'h5a, 1'b1, 1'b1);
    char_ready = 1'b0;
    @(negedge clk);
    chk("t3_full_pushpop", fifo_count, 16);
    drain();

    // no-push cases
    mb_write(CADDR, 4'd1, 16'h000f, 8'h11, 1'b0, 1'b0);
    mb_write(CADDR + 32'd4, 4'd0, 16'h000f, 8'h12, 1'b1, 1'b0);
    mb_write(CADDR, 4'd0, 16'h0001, 8'h13, 1'b0, 1'b0);
    set_aw(CADDR, 4'd1); tick(); awvalid = 1'b0;
    set_w(16'h000f, 8'h14, 1'b0); tick();
    set_w(16'h000f, 8'h15, 1'b1); tick(); clr_bus();
    @(negedge clk);
    chk("t4_nopush", fifo_count, 0);
    chk("t4_proto0", proto_err, 0);
    // AW in DATA ignored: beat uses first latched address
    set_aw(CADDR, 4'd0); tick(); awvalid = 1'b0;
    set_aw(32'h0000_1000, 4'd0); tick(); awvalid = 1'b0;
    set_w(16'h0f00, 8'h78, 1'b1); exp_q.push_back(8'h78); tick(); clr_bus();
    @(negedge clk);
    chk("t4_data_state", fifo_count, 1);
    drain();
    // W with no AW
    set_w(16'h000f, 8'h16, 1'b1); tick(); clr_bus();
    @(negedge clk);
    chk("t4_proto1", proto_err, 1);
    chk("t4_proto_nopush", fifo_count, 0);
    chk("t4_ovf_sticky", ovf_flag, 1);

    // verdicts
    wb_vld0 = 1'b1; wb_data0 = PASS + 64'd1; wb_vld1 = 1'b0; wb_data1 = PASS;
    tick(); wb_vld0 = 1'b0;
    @(negedge clk);
    chk("t5_nomatch", test_done, 0);
    wb_vld0 = 1'b1; wb_data0 = PASS; tick(); wb_vld0 = 1'b0;
    @(negedge clk);
    chk("t5_done", test_done, 1);
    chk("t5_pass", test_pass, 1);
    wb_vld1 = 1'b1; wb_data1 = FAILV; tick(); wb_vld1 = 1'b0;
    @(negedge clk);
    chk("t5_frozen_pass", test_pass, 1);
    do_reset();
    @(negedge clk);
    chk("t5_rst_done", test_done, 0);
    wb_vld0 = 1'b1; wb_data0 = PASS; wb_vld1 = 1'b1; wb_data1 = FAILV;
    tick(); wb_vld0 = 1'b0; wb_vld1 = 1'b0;
    @(negedge clk);
    chk("t5_conf_done", test_done, 1);
    chk("t5_conf_pass", test_pass, 0);
    wb_vld1 = 1'b1; wb_data1 = PASS; tick(); wb_vld1 = 1'b0;
    @(negedge clk);
    chk("t5_frozen_fail", test_pass, 0);

    // watchdog
    retire0 = 1'b0;
    do_reset();
    repeat (7) tick();
    @(negedge clk);
    chk("t6_wd_early", wd_timeout, 0);
    tick();
    @(negedge clk);
    chk("t6_wd", wd_timeout, 1);
    chk("t6_wd_done", test_done, 1);
    chk("t6_wd_pass", test_pass, 0);
    wb_vld0 = 1'b1; wb_data0 = PASS; tick(); wb_vld0 = 1'b0;
    @(negedge clk);
    chk("t6_wd_frozen", test_pass, 0);
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      retire0 = (i % 14 == 7);
      retire1 = (i % 14 == 0);
      tick();
    end
    retire0 = 1'b0; retire1 = 1'b0;
    @(negedge clk);
    chk("t6_no_timeout", wd_timeout, 0);
    chk("t6_no_done", test_done, 0);

    // async reset mid-window with state present
    mb_write(CADDR, 4'd0, 16'h000f, 8'h33, 1'b1, 1'b1);
    set_w(16'h000f, 8'h34, 1'b1); tick(); clr_bus();
    repeat (9) tick();
    @(negedge clk);
    chk("t7_pre_state", {char_valid, proto_err, wd_timeout}, 3'b111);
    #2 rst = 1'b1;
    #1 chk_all_zero("t7_async_rst");
    exp_q.delete();
    tick(); rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
